// File: rtl/redtin_pkg.sv
// Shared definitions for the readout path of the logic-analyzer capture core.
// Holds the readout FSM state type and the default word/address geometry, which
// the capture core uses as well, so both sides agree on buffer shape.
package redtin_pkg;

    localparam int unsigned DefaultDataWidth = 128;
    localparam int unsigned DefaultAddrWidth = 9;
    localparam logic [7:0]  DefaultSyncByte  = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StFetch,
        StLoad,
        StSend
    } state_e;

endpackage

// File: rtl/redtin_word_serializer.sv
// Holds one capture word and presents it one byte at a time, MSB byte first.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load           capture word into the shift register, restart byte count
//   word           capture word to load
//   shift          current byte was accepted downstream; advance to the next
//   msb_byte       byte currently presented (top 8 bits of the shift register)
//   last_accepted  shift happened on the final byte of the word
module redtin_word_serializer
    import redtin_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  shift,
    output logic [7:0]            msb_byte,
    output logic                  last_accepted
);

    localparam int unsigned Bytes    = DATA_WIDTH / 8;
    localparam int unsigned IdxWidth = (Bytes > 1) ? $clog2(Bytes) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Bytes - 1);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [IdxWidth-1:0]   idx_q, idx_d;

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (load) begin
            shreg_d = word;
            idx_d   = '0;
        end else if (shift) begin
            shreg_d = shreg_q << 8;
            idx_d   = idx_q + IdxWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    assign msb_byte      = shreg_q[DATA_WIDTH-1 -: 8];
    assign last_accepted = shift && (idx_q == LastIdx);

endmodule

// File: rtl/redtin_readout.sv
// Capture-buffer readout: after a start request (with capture done) sends a sync
// byte, then sweeps every buffer address and streams each word MSB byte first
// over a valid/ready byte interface towards the host UART.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle dump request
//   cap_done     capture core done level; dropping it aborts the dump
//   read_addr    capture buffer read address
//   read_data    capture buffer data, valid one clock after read_addr changes
//   tx_data      byte to the UART, tx_valid/tx_ready handshake
//   busy         dump in progress
//   dump_done    one-cycle pulse after the final byte of a full dump is accepted
module redtin_readout
    import redtin_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
    parameter logic [7:0]  SYNC_BYTE  = DefaultSyncByte
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  cap_done,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  dump_done
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  done_q, done_d;

    logic       ser_load;
    logic       ser_shift;
    logic       ser_last;
    logic [7:0] ser_byte;
    logic       addr_last;

    assign addr_last = (addr_q == {ADDR_WIDTH{1'b1}});

    redtin_word_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_serializer (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (ser_load),
        .word         (read_data),
        .shift        (ser_shift),
        .msb_byte     (ser_byte),
        .last_accepted(ser_last)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (start && cap_done) begin
                    state_d = StSync;
                    addr_d  = '0;
                end
            end
            StSync: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) begin
                    state_d = cap_done ? StFetch : StIdle;
                end
            end
            // Address is already stable here; read_data lands one clock later.
            StFetch: begin
                state_d = cap_done ? StLoad : StIdle;
            end
            StLoad: begin
                ser_load = 1'b1;
                state_d  = cap_done ? StSend : StIdle;
            end
            StSend: begin
                tx_valid = 1'b1;
                tx_data  = ser_byte;
                if (tx_ready) begin
                    ser_shift = 1'b1;
                    // An abort still lets the presented byte complete first.
                    if (!cap_done) begin
                        state_d = StIdle;
                    end else if (ser_last) begin
                        if (addr_last) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            state_d = StFetch;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign read_addr = addr_q;
    assign busy      = (state_q != StIdle);
    assign dump_done = done_q;

endmodule

// File: tb/tb_redtin_readout.sv
// Bench for redtin_readout: capture-buffer model with one clock read latency,
// byte scoreboard fed when dumps are requested, stall-stability monitor,
// a small vector table for the idle/start corner cases and scripted dumps.
module tb_redtin_readout;

    localparam int unsigned DW     = 128;
    localparam int unsigned AW     = 9;
    localparam int unsigned NWORDS = 512;
    localparam int unsigned NBYTES = DW / 8;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          cap_done = 1'b0;
    logic          tx_ready = 1'b0;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] read_data = '0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          busy;
    logic          dump_done;

    int total      = 0;
    int bad        = 0;
    int xfer_count = 0;
    int done_count = 0;

    bit         rand_ready = 1'b0;
    bit         word0_pat  = 1'b0;
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] mon_exp;

    typedef struct {
        logic       start;
        logic       cap_done;
        logic       ready;
        logic       push_sync;
        logic       busy;
        logic       valid;
        logic [7:0] data;
        logic       done;
    } vec_t;

    vec_t vecs[8];

    redtin_readout dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cap_done (cap_done),
        .read_addr(read_addr),
        .read_data(read_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .dump_done(dump_done)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        logic [7:0] b;
        if (word0_pat && a == '0) return 128'h00112233_44556677_8899AABB_CCDDEEFF;
        b = a[7:0];
        return {NBYTES{b}};
    endfunction

    // Capture core read port: registered, one clock latency.
    always @(posedge clk) read_data <= word_of(read_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic push_word(input logic [AW-1:0] a, input int nbytes);
        logic [DW-1:0] w;
        w = word_of(a);
        for (int i = 0; i < nbytes; i++) exp_q.push_back(w[DW-1-8*i -: 8]);
    endtask

    task automatic push_dump();
        exp_q.push_back(8'hA5);
        for (int a = 0; a < NWORDS; a++) push_word(AW'(a), NBYTES);
    endtask

    // Monitor: scoreboard pop on each transfer, stall stability, dump_done count.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                xfer_count++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL byte_extra: got %0h want none (t=%0t)", tx_data, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("byte", 32'(tx_data), 32'(mon_exp));
                end
            end
            if (dump_done) done_count++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    // Random backpressure when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    end

    task automatic run_dump(input bit rnd, input bit poke, input bit check_len);
        int  cycles;
        int  done_before;
        bit  seen;
        push_dump();
        done_before = done_count;
        @(posedge clk);
        #1;
        rand_ready = rnd;
        if (!rnd) tx_ready = 1'b1;
        cap_done = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 0;
        seen   = 1'b0;
        for (int c = 0; c < 40000 && !seen; c++) begin
            @(posedge clk);
            cycles++;
            #1;
            start = poke && (cycles == 100 || cycles == 5000);
            @(negedge clk);
            if (dump_done) seen = 1'b1;
        end
        check("dump_done_seen", 32'(seen), 32'd1);
        if (check_len) check("dump_cycles", 32'(cycles), 32'd9217);
        @(posedge clk);
        @(negedge clk);
        check("dump_done_one_clk", 32'(dump_done), 32'd0);
        check("busy_after_dump", 32'(busy), 32'd0);
        check("done_pulses", 32'(done_count - done_before), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        rand_ready = 1'b0;
        tx_ready   = 1'b1;
    endtask

    initial begin
        int  base;
        bit  found;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_read_addr", 32'(read_addr), 32'd0);
        check("rst_dump_done", 32'(dump_done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Start without cap_done is ignored.
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("nocap_tx_valid", 32'(tx_valid), 32'd0);
            check("nocap_busy", 32'(busy), 32'd0);
        end

        // Vector table: ignore rules, sync byte latency, stall, abort on sync byte.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            start    = vecs[i].start;
            cap_done = vecs[i].cap_done;
            tx_ready = vecs[i].ready;
            if (vecs[i].push_sync) exp_q.push_back(8'hA5);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].data));
            check($sformatf("vec%0d_done", i), 32'(dump_done), 32'(vecs[i].done));
        end
        check("vec_queue_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        tx_ready = 1'b1;

        // Full dump, no backpressure.
        run_dump(1'b0, 1'b0, 1'b1);

        // Full dump with patterned word 0 and random backpressure.
        word0_pat = 1'b1;
        run_dump(1'b1, 1'b0, 1'b0);
        word0_pat = 1'b0;

        // Abort while the 5th byte of word 10 is stalled.
        exp_q.push_back(8'hA5);
        for (int a = 0; a < 10; a++) push_word(AW'(a), NBYTES);
        push_word(AW'(10), 5);
        base = xfer_count;
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        cap_done = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(posedge clk);
            #1;
            if (xfer_count - base == 165) begin
                tx_ready = 1'b0;
                cap_done = 1'b0;
                found    = 1'b1;
            end
        end
        check("abort_reached", 32'(found), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_stall_addr", 32'(read_addr), 32'd10);
        check("abort_stall_data", 32'(tx_data), 32'h0A);
        check("abort_stall_busy", 32'(busy), 32'd1);
        base = done_count;
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(tx_valid), 32'd0);
        check("abort_no_done", 32'(done_count - base), 32'd0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-SEND.
        push_dump();
        @(posedge clk);
        #1;
        cap_done = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx_valid", 32'(tx_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_read_addr", 32'(read_addr), 32'd0);
        check("arst_tx_data", 32'(tx_data), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fresh dump after reset, with start pokes while busy.
        run_dump(1'b0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
